// File: rtl/core_mem_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port, the shared memory and the arbiter.
// The arbiter takes the slave view; the surrounding core/memory model takes the master view.
interface core_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;

  logic                  ls_req_i;
  logic                  ls_we_i;
  logic [ADDR_WIDTH-1:0] ls_addr_i;
  logic [DATA_WIDTH-1:0] ls_wdata_i;
  logic                  ls_gnt_o;
  logic                  ls_rvalid_o;
  logic [DATA_WIDTH-1:0] ls_rdata_o;

  logic                  err_o;
  logic                  busy_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ready_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    input  mem_ready_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output err_o, busy_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    output mem_ready_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  err_o, busy_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single-port memory with round-robin tie breaking
// and a per-access wait timeout that returns an error response.
module core_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic              clk,
  input logic              rst_n,
  core_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIfAcc, StLsAcc} state_e;

  // Abort happens in the ACC cycle whose entry count is TIMEOUT-1, giving TIMEOUT request cycles.
  localparam logic [7:0] WaitLimit = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  last_ls_q, last_ls_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            wait_q, wait_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  grant_if, grant_ls;
  logic                  in_acc, owner_ls, timeout;

  assign in_acc   = (state_q != StIdle);
  assign owner_ls = (state_q == StLsAcc);
  assign timeout  = !bus.mem_ready_i && (wait_q == WaitLimit);

  // Grants are combinational but suppressed while reset is asserted.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      grant_ls = bus.ls_req_i && (!bus.if_req_i || !last_ls_q);
      grant_if = bus.if_req_i && (!bus.ls_req_i || last_ls_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_ls) begin
          state_d   = StLsAcc;
          last_ls_d = 1'b1;
          addr_d    = bus.ls_addr_i;
          we_d      = bus.ls_we_i;
          wdata_d   = bus.ls_wdata_i;
          wait_d    = 8'd0;
        end else if (grant_if) begin
          state_d   = StIfAcc;
          last_ls_d = 1'b0;
          addr_d    = bus.if_addr_i;
          we_d      = 1'b0;
          wait_d    = 8'd0;
        end
      end
      StIfAcc, StLsAcc: begin
        if (bus.mem_ready_i) begin
          state_d     = StIdle;
          if_rvalid_d = !owner_ls;
          ls_rvalid_d = owner_ls;
          if (!owner_ls) begin
            if_rdata_d = bus.mem_rdata_i;
          end else if (!we_q) begin
            ls_rdata_d = bus.mem_rdata_i;
          end
        end else if (timeout) begin
          state_d     = StIdle;
          if_rvalid_d = !owner_ls;
          ls_rvalid_d = owner_ls;
          err_d       = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_ls_q   <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wait_q      <= 8'd0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.if_gnt_o    = grant_if;
  assign bus.ls_gnt_o    = grant_ls;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.ls_rvalid_o = ls_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_rdata_o  = ls_rdata_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = in_acc;
  assign bus.mem_req_o   = in_acc;
  assign bus.mem_we_o    = owner_ls && we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: reset, fetch, tie-break, alternation, timeout,
// mid-access reset and address isolation.
module tb_core_mem_arbiter;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  core_mem_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  core_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.if_req_i = 1'b1;
    bus.ls_req_i = 1'b1;
    #1;
    checks++; if (bus.if_gnt_o !== 1'b0) begin errors++;
      $display("FAIL rst_if_gnt got %0h exp 0", bus.if_gnt_o); end
    checks++; if (bus.ls_gnt_o !== 1'b0) begin errors++;
      $display("FAIL rst_ls_gnt got %0h exp 0", bus.ls_gnt_o); end
    checks++; if (bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++;
      $display("FAIL rst_req_busy got %0h%0h exp 00", bus.mem_req_o, bus.busy_o); end
    checks++; if (bus.if_rdata_o !== 32'h0 || bus.ls_rdata_o !== 32'h0) begin errors++;
      $display("FAIL rst_rdata got %0h/%0h exp 0", bus.if_rdata_o, bus.ls_rdata_o); end
    checks++; if (bus.mem_addr_o !== 10'h0 || bus.mem_wdata_o !== 32'h0) begin errors++;
      $display("FAIL rst_mem got %0h/%0h exp 0", bus.mem_addr_o, bus.mem_wdata_o); end
    checks++; if (bus.if_rvalid_o !== 1'b0 || bus.ls_rvalid_o !== 1'b0 || bus.err_o !== 1'b0)
      begin errors++; $display("FAIL rst_rvalid got %0h%0h%0h exp 000",
        bus.if_rvalid_o, bus.ls_rvalid_o, bus.err_o); end
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 10'h004;
    bus.mem_ready_i = 1'b0;
    #1;
    checks++; if (bus.if_gnt_o !== 1'b1 || bus.ls_gnt_o !== 1'b0) begin errors++;
      $display("FAIL fetch_gnt got %0h%0h exp 10", bus.if_gnt_o, bus.ls_gnt_o); end
    @(negedge clk);
    bus.if_req_i    = 1'b0;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h00A00093;
    #1;
    checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin errors++;
      $display("FAIL fetch_req got %0h%0h exp 10", bus.mem_req_o, bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 10'h004) begin errors++;
      $display("FAIL fetch_addr got %0h exp 4", bus.mem_addr_o); end
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    checks++; if (bus.if_rvalid_o !== 1'b1 || bus.err_o !== 1'b0) begin errors++;
      $display("FAIL fetch_rvalid got %0h%0h exp 10", bus.if_rvalid_o, bus.err_o); end
    checks++; if (bus.if_rdata_o !== 32'h00A00093) begin errors++;
      $display("FAIL fetch_rdata got %0h exp a00093", bus.if_rdata_o); end
    checks++; if (bus.busy_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++;
      $display("FAIL fetch_idle got %0h%0h exp 00", bus.busy_o, bus.mem_req_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.if_rvalid_o !== 1'b0) begin errors++;
      $display("FAIL fetch_pulse got %0h exp 0", bus.if_rvalid_o); end
  endtask

  task automatic test_tie();
    do_reset();
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 10'h008;
    bus.ls_req_i    = 1'b1;
    bus.ls_we_i     = 1'b1;
    bus.ls_addr_i   = 10'h010;
    bus.ls_wdata_i  = 32'hDEADBEEF;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h12345678;
    #1;
    checks++; if (bus.ls_gnt_o !== 1'b1 || bus.if_gnt_o !== 1'b0) begin errors++;
      $display("FAIL tie_first got ls%0h if%0h exp ls1 if0", bus.ls_gnt_o, bus.if_gnt_o); end
    @(negedge clk);
    bus.ls_req_i = 1'b0;
    #1;
    checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1) begin errors++;
      $display("FAIL tie_store got %0h%0h exp 11", bus.mem_req_o, bus.mem_we_o); end
    checks++; if (bus.mem_wdata_o !== 32'hDEADBEEF || bus.mem_addr_o !== 10'h010) begin
      errors++; $display("FAIL tie_wdata got %0h@%0h exp deadbeef@10",
        bus.mem_wdata_o, bus.mem_addr_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.ls_rvalid_o !== 1'b1 || bus.ls_rdata_o !== 32'h0) begin errors++;
      $display("FAIL tie_ls_rsp got %0h/%0h exp 1/0", bus.ls_rvalid_o, bus.ls_rdata_o); end
    checks++; if (bus.if_gnt_o !== 1'b1) begin errors++;
      $display("FAIL tie_if_gnt got %0h exp 1", bus.if_gnt_o); end
    @(negedge clk);
    bus.if_req_i = 1'b0;
    #1;
    checks++; if (bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 10'h008) begin errors++;
      $display("FAIL tie_fetch got we%0h@%0h exp we0@8", bus.mem_we_o, bus.mem_addr_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.if_rvalid_o !== 1'b1 || bus.if_rdata_o !== 32'h12345678) begin
      errors++; $display("FAIL tie_if_rsp got %0h/%0h exp 1/12345678",
        bus.if_rvalid_o, bus.if_rdata_o); end
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic test_alternate();
    int g[6];
    int n = 0;
    @(negedge clk);
    bus.if_req_i    = 1'b1;
    bus.ls_req_i    = 1'b1;
    bus.ls_we_i     = 1'b0;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hCAFEF00D;
    for (int c = 0; c < 30 && n < 6; c++) begin
      #1;
      checks++; if ((bus.if_gnt_o && bus.ls_gnt_o) || (bus.if_rvalid_o && bus.ls_rvalid_o))
        begin errors++; $display("FAIL alt_excl got gnt %0h%0h rv %0h%0h exp one-hot",
          bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o); end
      if (bus.ls_gnt_o) begin g[n] = 1; n++; end
      else if (bus.if_gnt_o) begin g[n] = 0; n++; end
      @(negedge clk);
    end
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
    checks++; if (n != 6) begin errors++; $display("FAIL alt_count got %0d exp 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (g[i] != ((i % 2 == 0) ? 1 : 0)) begin errors++;
        $display("FAIL alt_order[%0d] got ls=%0d exp ls=%0d", i, g[i], (i % 2 == 0)); end
    end
    repeat (3) @(negedge clk);
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit seen = 1'b0;
    @(negedge clk);
    bus.ls_req_i    = 1'b1;
    bus.ls_we_i     = 1'b0;
    bus.ls_addr_i   = 10'h020;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'hBADBAD00;
    #1;
    checks++; if (bus.ls_gnt_o !== 1'b1) begin errors++;
      $display("FAIL to_gnt got %0h exp 1", bus.ls_gnt_o); end
    @(negedge clk);
    bus.ls_req_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.mem_req_o) cnt++;
      if (bus.ls_rvalid_o) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_rvalid got none exp pulse"); end
    checks++; if (cnt != 15) begin errors++; $display("FAIL to_cycles got %0d exp 15", cnt); end
    checks++; if (bus.err_o !== 1'b1) begin errors++;
      $display("FAIL to_err got %0h exp 1", bus.err_o); end
    checks++; if (bus.ls_rdata_o !== 32'hCAFEF00D) begin errors++;
      $display("FAIL to_rdata got %0h exp cafef00d", bus.ls_rdata_o); end
    checks++; if (bus.busy_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++;
      $display("FAIL to_idle got %0h%0h exp 00", bus.busy_o, bus.mem_req_o); end
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.ls_rvalid_o !== 1'b0 || bus.if_rvalid_o !== 1'b0 || bus.err_o !== 1'b0)
      begin errors++; $display("FAIL idle_ready got %0h%0h%0h exp 000",
        bus.ls_rvalid_o, bus.if_rvalid_o, bus.err_o); end
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 10'h004;
    bus.mem_ready_i = 1'b0;
    #1;
    checks++; if (bus.if_gnt_o !== 1'b1) begin errors++;
      $display("FAIL rm_gnt got %0h exp 1", bus.if_gnt_o); end
    @(negedge clk);
    bus.if_req_i = 1'b0;
    @(negedge clk);
    rst_n           = 1'b0;
    bus.if_req_i    = 1'b1;
    bus.ls_req_i    = 1'b1;
    bus.ls_we_i     = 1'b0;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.if_gnt_o !== 1'b0 || bus.ls_gnt_o !== 1'b0) begin errors++;
      $display("FAIL rm_gnt_rst got %0h%0h exp 00", bus.if_gnt_o, bus.ls_gnt_o); end
    checks++; if (bus.if_rvalid_o !== 1'b0 || bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0)
      begin errors++; $display("FAIL rm_drop got %0h%0h%0h exp 000",
        bus.if_rvalid_o, bus.mem_req_o, bus.busy_o); end
    checks++; if (bus.if_rdata_o !== 32'h0 || bus.ls_rdata_o !== 32'h0 ||
                  bus.mem_addr_o !== 10'h0 || bus.mem_wdata_o !== 32'h0) begin errors++;
      $display("FAIL rm_zero got %0h/%0h/%0h/%0h exp 0", bus.if_rdata_o, bus.ls_rdata_o,
        bus.mem_addr_o, bus.mem_wdata_o); end
    rst_n           = 1'b1;
    bus.mem_ready_i = 1'b0;
    #1;
    checks++; if (bus.ls_gnt_o !== 1'b1 || bus.if_gnt_o !== 1'b0) begin errors++;
      $display("FAIL rm_tie got ls%0h if%0h exp ls1 if0", bus.ls_gnt_o, bus.if_gnt_o); end
    checks++; if (bus.if_rvalid_o !== 1'b0) begin errors++;
      $display("FAIL rm_no_rvalid got %0h exp 0", bus.if_rvalid_o); end
    @(negedge clk);
    bus.if_req_i    = 1'b0;
    bus.ls_req_i    = 1'b0;
    bus.mem_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic test_addr_hold();
    @(negedge clk);
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 10'h004;
    bus.mem_ready_i = 1'b0;
    #1;
    checks++; if (bus.if_gnt_o !== 1'b1) begin errors++;
      $display("FAIL ah_gnt got %0h exp 1", bus.if_gnt_o); end
    @(negedge clk);
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = 10'h3FF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.mem_addr_o !== 10'h004 || bus.mem_req_o !== 1'b1) begin errors++;
        $display("FAIL ah_addr[%0d] got %0h req%0h exp 4 req1", c, bus.mem_addr_o,
          bus.mem_req_o); end
      @(negedge clk);
    end
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h11223344;
    #1;
    checks++; if (bus.mem_addr_o !== 10'h004) begin errors++;
      $display("FAIL ah_addr_last got %0h exp 4", bus.mem_addr_o); end
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    checks++; if (bus.if_rvalid_o !== 1'b1 || bus.err_o !== 1'b0 ||
                  bus.if_rdata_o !== 32'h11223344) begin errors++;
      $display("FAIL ah_rsp got %0h%0h/%0h exp 10/11223344", bus.if_rvalid_o, bus.err_o,
        bus.if_rdata_o); end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.ls_req_i    = 1'b0;
    bus.ls_we_i     = 1'b0;
    bus.ls_addr_i   = '0;
    bus.ls_wdata_i  = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    test_reset();
    test_fetch();
    test_tie();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_addr_hold();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
